fetch_queue_stage: RTL and testbench
====================================

// Module: fetch_queue_stage
// PURPOSE
// - Fetch front-end of the 16-bit pipeline. Owns the PC register and issues in-order reads to instruction memory.
// - Buffers returned words in a small queue and presents {instr, pc, pc+2} to decode with a valid/ready handshake.
// - Takes branch/jump redirects from memory stage; stops fetching at HALT.
// PARAMETERS
// - WIDTH    16       data/address width
// - QDEPTH   2        queue entries (power of 2, >=2)
// - RESET_PC 16'h0000 PC loaded on reset
// PORTS
// - clk            in   1      clock, all state updates on posedge
// - rst            in   1      synchronous active-high reset
// - imem_req       out  1      read request to instruction memory
// - imem_addr      out  WIDTH  request address (= pc_q)
// - imem_gnt       in   1      request accepted this cycle
// - imem_rvalid    in   1      read data valid (>=1 cycle after gnt)
// - imem_rdata     in   WIDTH  returned instruction word
// - redirect_valid in   1      branch/jump taken, flush and refetch
// - redirect_pc    in   WIDTH  new PC target
// - id_ready       in   1      decode accepts head entry
// - if_valid       out  1      head entry valid
// - if_instr       out  WIDTH  head instruction
// - if_pc          out  WIDTH  head instruction address
// - if_pc_next     out  WIDTH  head address + 2 (feeds pc2 / link path)
// - halted         out  1      HALT fetched; fetching stopped
// - err            out  1      misaligned fetch (only with ALIGN_CHECK_EN)
// BEHAVIOUR
// - Reset: pc_q=RESET_PC, queue empty, state IDLE, drop=0; imem_req=0, if_valid=0, halted=0, err=0 (rst dominates all).
// - States IDLE / WAIT / HALTED; max one outstanding read; responses in order.
// - IDLE: imem_req = ~halted & ~redirect_valid & (count + 0 < QDEPTH); on imem_req&imem_gnt: pc_q<=pc_q+2 (16'hFFFE wraps to 0), ->WAIT.
// - Credit rule: a request is issued only if count+outstanding < QDEPTH, so a response never finds the queue full.
// - WAIT: imem_req=0. On imem_rvalid: if drop, discard word, clear drop, ->IDLE; else push {rdata, addr, addr+2}.
// - HALT = rdata[15:11]==5'b00000: push word, ->HALTED, halted=1 next cycle; no further requests.
// - Else after push ->IDLE; next request earliest the following cycle.
// - HALTED: queue still drains to decode; leaves only on redirect (->IDLE, halted=0) or rst.
// - Output: if_valid = count!=0; if_* from head, combinational from queue regs; pop on if_valid&id_ready.
// - Push and pop in same cycle: both happen, count unchanged.
// - Redirect (highest priority, any state): queue flushed same edge (if_valid=0 next cycle), pc_q<=redirect_pc, halted<=0;
//     pop ignored that cycle; in WAIT set drop=1 and stay WAIT; if rvalid in same cycle word discarded, ->IDLE, drop=0.
// - Second redirect while drop=1: pc_q updated again, drop stays 1.
// - Latency: gnt at N, rvalid at N+1 -> if_valid at N+2; redirect at N -> new-target req at N+1 (IDLE) else after stale rvalid.
// - Throughput with single-cycle memory: one instr per 2 cycles (request/response alternate).
// CONFIGURATION
// - ALIGN_CHECK_EN defined: redirect_pc[0]==1 sets err=1 (sticky until rst), state ->HALTED, no request issued.
// - ALIGN_CHECK_EN undefined: err tied 0; redirect_pc[0] forced to 0 before load.
// TESTING
// - Reset, mem returns 16'h4000 (gnt same cycle, rvalid +1), id_ready=1 -> req addr 0x0000, if_valid with if_pc=0x0000, if_pc_next=0x0002.
// - id_ready=0, continuous fetch -> exactly QDEPTH=2 entries then imem_req stays 0; id_ready=1 resumes at addr 0x0004.
// - Redirect to 0x0040 while WAIT on addr 0x0006 -> stale word dropped, if_valid=0, next req addr 0x0040, if_pc=0x0040.
// - Return 16'h0000 (HALT) at 0x0010 -> halted=1, no further imem_req, HALT entry still delivered; redirect 0x0020 restarts.
// - pc_q=0xFFFE fetch -> next req addr 0x0000, if_pc_next=0x0000.
// - ALIGN_CHECK_EN: redirect 0x0031 -> err=1, halted=1, no imem_req; rst clears err.

Source files
------------

// File: rtl/fetch_queue_stage.sv
// Fetch front-end: owns the PC, issues in-order reads to instruction memory and queues
// returned words for decode. Optional misaligned-redirect trap under `ALIGN_CHECK_EN.
module fetch_queue_stage #(
  parameter int               WIDTH    = 16,
  parameter int               QDEPTH   = 2,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             id_ready,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_instr,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_pc_next,
  output logic             halted,
  output logic             err
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] req_addr_q;
  logic             drop_q;

  logic [WIDTH-1:0] instr_mem [QDEPTH];
  logic [WIDTH-1:0] addr_mem  [QDEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  logic             grant;
  logic             push;
  logic             pop;
  logic             is_halt;
  logic             stale_out;
  logic [WIDTH-1:0] redirect_target;
  logic             misaligned;

`ifdef ALIGN_CHECK_EN
  logic err_q;
  assign redirect_target = redirect_pc;
  assign misaligned      = redirect_pc[0];
  assign err             = err_q;
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb   = redirect_pc[0];
  assign redirect_target = {redirect_pc[WIDTH-1:1], 1'b0};
  assign misaligned      = 1'b0;
  assign err             = 1'b0;
`endif

  // A read is still in flight after this cycle if we are waiting on it (or must discard it)
  // and it does not return now; a redirect must then keep waiting for that stale word.
  assign stale_out = ((state_q == WAIT) || drop_q) && !imem_rvalid;

  assign imem_req  = !rst && (state_q == IDLE) && !redirect_valid && (count < CW'(QDEPTH));
  assign imem_addr = pc_q;
  assign grant     = imem_req && imem_gnt;
  assign is_halt   = (imem_rdata[WIDTH-1 -: 5] == 5'b00000);
  assign push      = (state_q == WAIT) && imem_rvalid && !drop_q && !redirect_valid;
  assign pop       = if_valid && id_ready && !redirect_valid;

  assign if_valid   = (count != '0);
  assign if_instr   = instr_mem[rd_ptr];
  assign if_pc      = addr_mem[rd_ptr];
  assign if_pc_next = if_pc + WIDTH'(2);
  assign halted     = (state_q == HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      drop_q     <= 1'b0;
`ifdef ALIGN_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else if (redirect_valid) begin
      pc_q   <= redirect_target;
      drop_q <= stale_out;
      if (misaligned) begin
        state_q <= HALTED;
`ifdef ALIGN_CHECK_EN
        err_q   <= 1'b1;
`endif
      end else begin
        state_q <= stale_out ? WAIT : IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            req_addr_q <= pc_q;
            pc_q       <= pc_q + WIDTH'(2);
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            drop_q <= 1'b0;
            if (!drop_q && is_halt) state_q <= HALTED;
            else                    state_q <= IDLE;
          end
        end
        HALTED: begin
          // Only a read abandoned by a misaligned redirect can still be outstanding here.
          if (imem_rvalid) drop_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata;
      addr_mem[wr_ptr]  <= req_addr_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: memory responder model, expected-entry scoreboard
// and a decode-side monitor. Covers the ALIGN_CHECK_EN trap when that macro is defined.
module tb_fetch_queue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_next;
  logic        halted;
  logic        err;

  logic        gnt_en;
  int          lat;
  logic [15:0] halt_at;
  logic [47:0] exp_q[$];
  logic [15:0] req_log[$];
  int          tests = 0;
  int          fails = 0;
  int          base;
  int          t;

  fetch_queue_stage #(.WIDTH(16), .QDEPTH(2), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_next(if_pc_next), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  assign imem_gnt = imem_req & gnt_en;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == halt_at) return 16'h0000;
    return 16'h4000 | (a & 16'h07FF);
  endfunction

  task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expectEntry(input logic [15:0] instr, input logic [15:0] pc, input logic [15:0] nxt);
    exp_q.push_back({instr, pc, nxt});
  endtask

  task automatic applyStimulus(input logic [15:0] target);
    redirect_pc    = target;
    redirect_valid = 1'b1;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  task automatic waitReqs(input int n, input string name);
    t = 0;
    while (req_log.size() < n && t < 60) begin
      tick(1);
      t++;
    end
    if (req_log.size() < n) checkOutput(name, 48'(req_log.size()), 48'(n));
  endtask

  task automatic waitDrain(input string name);
    t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      tick(1);
      t++;
    end
    checkOutput(name, 48'(exp_q.size()), 48'd0);
  endtask

  // Memory model: grant seen mid-cycle, word returned lat cycles later for one cycle.
  initial begin
    logic [15:0] a;
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    forever begin
      @(negedge clk);
      if (imem_req && imem_gnt) begin
        a = imem_addr;
        req_log.push_back(a);
        repeat (lat) @(posedge clk);
        #1;
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(a);
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
      end
    end
  end

  // Decode-side monitor
  initial begin
    logic [47:0] e;
    forever begin
      @(negedge clk);
      if (!rst && if_valid && id_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected entry", {if_instr, if_pc, if_pc_next}, 48'h0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("entry {instr,pc,pc_next}", {if_instr, if_pc, if_pc_next}, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; gnt_en = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 16'h0000; lat = 1; halt_at = 16'h0001;
    tick(3);
    checkOutput("reset imem_req", 48'(imem_req), 48'd0);
    checkOutput("reset if_valid", 48'(if_valid), 48'd0);
    checkOutput("reset halted", 48'(halted), 48'd0);
    checkOutput("reset err", 48'(err), 48'd0);
    rst = 1'b0;

    // First fetch: gnt at N, rvalid at N+1, head valid at N+2
    checkOutput("first req addr", 48'(imem_addr), 48'h0000);
    expectEntry(16'h4000, 16'h0000, 16'h0002);
    id_ready = 1'b1;
    gnt_en   = 1'b1;
    tick(1);
    gnt_en = 1'b0;
    checkOutput("N+1 if_valid", 48'(if_valid), 48'd0);
    checkOutput("N+1 imem_req", 48'(imem_req), 48'd0);
    tick(1);
    checkOutput("N+2 head", {15'd0, if_valid, if_instr, if_pc, if_pc_next}, {15'd0, 1'b1, 48'h4000_0000_0002});
    waitDrain("drain first");

    // Back-pressure: queue fills at two entries, then resumes at 0x0004
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    base = req_log.size();
    expectEntry(16'h4000, 16'h0000, 16'h0002);
    expectEntry(16'h4002, 16'h0002, 16'h0004);
    expectEntry(16'h4004, 16'h0004, 16'h0006);
    id_ready = 1'b0;
    gnt_en   = 1'b1;
    tick(10);
    checkOutput("full req count", 48'(req_log.size() - base), 48'd2);
    checkOutput("full imem_req", 48'(imem_req), 48'd0);
    checkOutput("full head pc", {15'd0, if_valid, 16'h0, if_pc, 16'h0}, {15'd0, 1'b1, 48'h0});
    id_ready = 1'b1;
    waitReqs(base + 3, "resume timeout");
    gnt_en = 1'b0;
    if (req_log.size() >= base + 3) checkOutput("resume addr", 48'(req_log[base+2]), 48'h0004);
    waitDrain("drain backpressure");

    // Redirect while waiting on 0x0006: stale word dropped
    lat  = 3;
    base = req_log.size();
    gnt_en = 1'b1;
    waitReqs(base + 1, "stale req timeout");
    if (req_log.size() >= base + 1) checkOutput("stale req addr", 48'(req_log[base]), 48'h0006);
    lat = 1;
    applyStimulus(16'h0040);
    checkOutput("drop imem_req", 48'(imem_req), 48'd0);
    checkOutput("drop if_valid", 48'(if_valid), 48'd0);
    expectEntry(16'h4040, 16'h0040, 16'h0042);
    waitReqs(base + 2, "redirect req timeout");
    gnt_en = 1'b0;
    if (req_log.size() >= base + 2) checkOutput("redirect req addr", 48'(req_log[base+1]), 48'h0040);
    waitDrain("drain redirect");

    // HALT at 0x0010
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    halt_at = 16'h0010;
    base = req_log.size();
    for (int i = 0; i < 8; i++)
      expectEntry(16'h4000 | 16'(2*i), 16'(2*i), 16'(2*i + 2));
    expectEntry(16'h0000, 16'h0010, 16'h0012);
    gnt_en = 1'b1;
    t = 0;
    while (!halted && t < 100) begin
      tick(1);
      t++;
    end
    checkOutput("halted set", 48'(halted), 48'd1);
    tick(6);
    checkOutput("halt req count", 48'(req_log.size() - base), 48'd9);
    checkOutput("halt imem_req", 48'(imem_req), 48'd0);
    checkOutput("halt sticky", 48'(halted), 48'd1);
    waitDrain("drain halt");
    halt_at = 16'h0001;
    expectEntry(16'h4020, 16'h0020, 16'h0022);
    applyStimulus(16'h0020);
    checkOutput("halt cleared", 48'(halted), 48'd0);
    waitReqs(base + 10, "restart timeout");
    gnt_en = 1'b0;
    if (req_log.size() >= base + 10) checkOutput("restart addr", 48'(req_log[base+9]), 48'h0020);
    waitDrain("drain restart");

    // PC wrap at 0xFFFE
    expectEntry(16'h47FE, 16'hFFFE, 16'h0000);
    expectEntry(16'h4000, 16'h0000, 16'h0002);
    applyStimulus(16'hFFFE);
    base = req_log.size();
    gnt_en = 1'b1;
    waitReqs(base + 2, "wrap timeout");
    gnt_en = 1'b0;
    if (req_log.size() >= base + 2) begin
      checkOutput("wrap addr FFFE", 48'(req_log[base]), 48'hFFFE);
      checkOutput("wrap addr 0000", 48'(req_log[base+1]), 48'h0000);
    end
    waitDrain("drain wrap");

`ifdef ALIGN_CHECK_EN
    base = req_log.size();
    gnt_en = 1'b1;
    applyStimulus(16'h0031);
    tick(3);
    checkOutput("align err", 48'(err), 48'd1);
    checkOutput("align halted", 48'(halted), 48'd1);
    checkOutput("align imem_req", 48'(imem_req), 48'd0);
    checkOutput("align no req", 48'(req_log.size() - base), 48'd0);
    gnt_en = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("align err cleared", 48'(err), 48'd0);
    checkOutput("align halted cleared", 48'(halted), 48'd0);
`else
    expectEntry(16'h4030, 16'h0030, 16'h0032);
    applyStimulus(16'h0031);
    base = req_log.size();
    gnt_en = 1'b1;
    waitReqs(base + 1, "odd redirect timeout");
    gnt_en = 1'b0;
    if (req_log.size() >= base + 1) checkOutput("odd redirect addr", 48'(req_log[base]), 48'h0030);
    checkOutput("err tied low", 48'(err), 48'd0);
    waitDrain("drain odd redirect");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
